// File: rtl/priority_code_decoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_code_decoder
// Description : FIFO-buffered decoder of 2-bit priority codes into one-hot
//               words, with valid/ready handshakes, flush and a saturating
//               count of delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_code_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_code,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_onehot,
    output logic [1:0]                 out_code,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           dec_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_level = (PTR_W + 1)'(DEPTH);

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic [CNT_W-1:0] r_dec_count;

    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic [1:0]       w_head;

    // Ready depends only on the registered level, so out_ready never reaches in_ready.
    assign in_ready    = (r_level != c_full_level);
    assign w_not_empty = (r_level != '0);
    assign w_push      = in_valid && in_ready;
    assign w_pop       = w_not_empty && out_ready;
    assign w_head      = r_mem[r_rd_ptr];

    assign out_valid   = w_not_empty;
    assign out_code    = w_not_empty ? w_head : 2'b00;
    assign out_onehot  = w_not_empty ? (4'b0001 << w_head) : 4'b0000;
    assign level       = r_level;
    assign dec_count   = r_dec_count;

    // Storage is not reset; stale entries are unreachable once level is zero.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_dec_count <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (r_dec_count != '1) begin
                    r_dec_count <= r_dec_count + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_priority_code_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_code_decoder
// Description : Directed and random stimulus against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_code_decoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             in_code;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0]             out_onehot;
    logic [1:0]             out_code;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       dec_count;

    int total = 0;
    int bad   = 0;

    logic [1:0] q [$];
    int         m_cnt = 0;

    priority_code_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .level      (level),
        .dec_count  (dec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".in_ready"},  32'(in_ready),   32'(n < DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid),  32'(n > 0));
        chk({tag, ".out_code"},  32'(out_code),   (n > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".onehot"},    32'(out_onehot), (n > 0) ? 32'(2 ** q[0]) : 32'd0);
        chk({tag, ".level"},     32'(level),      32'(n));
        chk({tag, ".dec_count"}, 32'(dec_count),  32'(m_cnt));
    endtask

    // One clock: apply inputs, let the model follow the handshake rules, compare.
    task automatic cycle(input string tag, input logic iv, input logic [1:0] code,
                         input logic ordy, input logic fl);
        bit do_push, do_pop;
        in_valid  = iv;
        in_code   = code;
        out_ready = ordy;
        flush     = fl;
        do_push   = iv && (q.size() < DEPTH);
        do_pop    = ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                if (m_cnt < MAXC) m_cnt++;
            end
            if (do_push) q.push_back(code);
        end
        chk_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = 2'b00; flush = 1'b0; out_ready = 1'b0;
        #3;
        chk_all("reset_hold");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk_all("reset_release");

        // Fill with all four codes while the consumer stalls, then drain in order.
        for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 2'(i), 1'b0, 1'b0);
        cycle("full_stall", 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 2'b00, 1'b1, 1'b0);
        chk("drain_count", 32'(dec_count), 32'd4);

        // Full buffer: a simultaneous push is refused while the pop proceeds.
        for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 2'(3 - i), 1'b0, 1'b0);
        cycle("full_push_pop", 1'b1, 2'b01, 1'b1, 1'b0);
        chk("full_push_pop.lvl3", 32'(level), 32'd3);

        // Level 2 steady streaming of code 11 across pointer wrap.
        cycle("to_lvl2", 1'b0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("stream", 1'b1, 2'b11, 1'b1, 1'b0);
        chk("stream.lvl2", 32'(level), 32'd2);

        // Flush at level 3 overrides push and pop and is not counted.
        cycle("to_lvl3", 1'b1, 2'b10, 1'b0, 1'b0);
        cycle("flush", 1'b1, 2'b01, 1'b1, 1'b1);
        chk("flush.empty", 32'(out_valid), 32'd0);

        // Empty buffer ignores out_ready.
        cycle("empty_pop", 1'b0, 2'b00, 1'b1, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 300; i++)
            cycle("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));

        // Enough streaming pops to pin the counter at its ceiling.
        cycle("prime", 1'b1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++)
            cycle("saturate", 1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        chk("saturate.255", 32'(dec_count), 32'd255);

        // Asynchronous reset mid-stream at level 2.
        cycle("pre_rst_flush", 1'b0, 2'b00, 1'b0, 1'b1);
        cycle("pre_rst_a", 1'b1, 2'b10, 1'b0, 1'b0);
        cycle("pre_rst_b", 1'b1, 2'b01, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_cnt = 0;
        chk_all("async_rst");
        @(posedge clk); #1;
        chk_all("rst_held");
        rst_n = 1'b1;
        cycle("post_rst_push", 1'b1, 2'b11, 1'b0, 1'b0);
        cycle("post_rst_pop", 1'b0, 2'b00, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_code_decoder.md
PRIORITY_CODE_DECODER -- requirements
Module: priority_code_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered codes (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the decoded-item counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  producer presents a code this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a code this cycle.
REQ-007 SHALL have port in_code  input  2  2-bit priority code (00..11) to decode.
REQ-008 SHALL have port flush  input  1  synchronous discard of all buffered codes.
REQ-009 SHALL have port out_valid  output  1  a decoded word is presented.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the decoded word.
REQ-011 SHALL have port out_onehot  output  4  one-hot decode of the head code (00->0001, 01->0010, 10->0100, 11->1000).
REQ-012 SHALL have port out_code  output  2  the raw head code, unmodified.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  number of codes currently buffered.
REQ-014 SHALL have port dec_count  output  CNT_W  saturating count of completed output handshakes.

Function
REQ-015 SHALL accept a code (push) when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-016 SHALL complete an output (pop) when out_valid=1 and out_ready=1 at a rising clk edge.
REQ-017 SHALL drive in_ready = 1 exactly when level < DEPTH, derived from registered state only (no combinational path from out_ready).
REQ-018 SHALL drive out_valid = 1 exactly when level > 0.
REQ-019 SHALL store codes in arrival order and present them in the same order (FIFO).
REQ-020 SHALL present a code pushed into an empty buffer on out_valid/out_onehot one cycle after the push edge (no same-cycle fall-through).
REQ-021 SHALL drive out_onehot = 4'b0000 and out_code = 2'b00 whenever out_valid = 0.
REQ-022 SHALL keep out_onehot, out_code stable while out_valid=1 and out_ready=0.
REQ-023 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-024 SHALL, on simultaneous push and pop with 0 < level < DEPTH, leave level unchanged and advance both pointers.
REQ-025 SHALL, when full (level=DEPTH), ignore in_valid (in_ready=0) even if a pop occurs that same cycle.
REQ-026 SHALL, when empty, perform no pop regardless of out_ready.
REQ-027 SHALL, on flush=1, set level, read and write pointers to 0 at the next edge; flush overrides any push or pop that cycle, and the popped item is not counted.
REQ-028 SHALL increment dec_count by 1 per pop and hold at 2^CNT_W-1 once reached (no wrap); flush does not clear it.
REQ-029 SHALL never drive out_onehot with more than one bit set.

Reset
REQ-030 SHALL, while rst_n=0, immediately force level=0, pointers=0, dec_count=0, out_valid=0, out_onehot=0, out_code=0, in_ready=1 (after reset deasserts).
REQ-031 SHALL discard any buffered codes and in-flight handshake on reset assertion mid-operation; buffer storage contents need not be cleared.
REQ-032 SHALL resume accepting pushes at the first rising clk edge after rst_n returns to 1.

Verification
REQ-033 SHALL cover: push codes 00,01,10,11 with out_ready=0 -> level=4, in_ready=0, out_onehot=0001; then out_ready=1 -> 0001,0010,0100,1000 over 4 cycles, dec_count=4.
REQ-034 SHALL cover: full buffer, in_valid=1 and out_ready=1 same cycle -> one pop, no push, level 4->3.
REQ-035 SHALL cover: level=2, continuous push 11 and pop for 10 cycles -> level stays 2, pointers wrap, order preserved.
REQ-036 SHALL cover: level=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, out_onehot=0000, dec_count unchanged.
REQ-037 SHALL cover: CNT_W=8, 260 pops -> dec_count=255 held.
REQ-038 SHALL cover: rst_n pulsed low mid-stream at level=2 -> outputs zero asynchronously before next clk edge, in_ready=1 after release.
